proc_cmd_issuer: RTL and testbench
==================================

Name: proc_cmd_issuer

Overview:
- Command-issuing end of the proc wait-time interface. Accepts timed requests from a scheduler and drives the command-code and per-channel time buses that the downstream clock-gating consumer samples.
- Drives cmd_type_M, proc_rel_time, proc_ext_time and event_proc.
- Tracks each channel's outstanding wait with a countdown.
- Raises ckg_ind when every channel is quiescent, so the consumer may gate its clock.

Parameters:
- PARA, 2, width of every time value and countdown.
- NUM_CH, 2, number of proc channels (unpacked array depth); must be >= 1.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted this cycle when req_valid && req_ready.
- req_type  input  2  0=REL, 1=EXT, 2=EVT, 3=reserved (never accepted).
- req_ch  input  $clog2(NUM_CH) (min 1)  target channel.
- req_time  input  PARA  wait time in clk cycles.
- cmd_type_M  output  5  issued command code, one-cycle strobe.
- proc_rel_time  output  [PARA-1:0] x [NUM_CH-1:0]  last REL time per channel.
- proc_ext_time  output  [PARA-1:0] x [NUM_CH-1:0]  last EXT time per channel.
- event_proc  output  [PARA-1:0] x [NUM_CH-1:0]  last EVT time per channel.
- done  output  NUM_CH  per-channel one-cycle completion pulse.
- busy  output  NUM_CH  channel has an outstanding wait.
- ckg_ind  output  1  registered; 1 = all channels idle, clock may be gated.

Behaviour:
- Reset (rst=1 at posedge): all state is cleared.
  - Outputs: cmd_type_M=0, all time arrays=0, done=0, busy=0, ckg_ind=1, every channel FSM in IDLE.
  - Reset mid-operation abandons all countdowns; no done pulse is produced.
- req_ready is combinational, and is 1 only when all of these hold:
  - rst=0;
  - channel FSM[req_ch] is IDLE;
  - req_type != 3;
  - req_ch < NUM_CH.
- At most one request is accepted per cycle.
- Per-channel FSM: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE: on accept, load the countdown with req_time, latch the type, go to ISSUE. busy=1 from the next cycle.
  - ISSUE (exactly 1 cycle): cmd_type_M = 5'd1 (REL), 5'd2 (EXT) or 5'd3 (EVT). The matching array entry [ch] is updated with req_time; the other two arrays hold their values. Next state is WAIT.
  - WAIT: the countdown decrements by 1 per cycle. When the count is 0, pulse done[ch] for 1 cycle, clear busy, go to IDLE.
  - req_time=0 gives ISSUE, then WAIT with count 0, with done in that WAIT cycle.
- Latency and wrap:
  - Accept to done = req_time + 2 cycles.
  - The countdown never wraps: decrement applies only while the count is nonzero. Max req_time = 2^PARA-1.
- cmd_type_M is 0 in every cycle where no channel is in ISSUE. Only one channel can be in ISSUE per cycle, because only one accept is allowed per cycle.
- A new accept on a channel is allowed the cycle after its done (the channel is back in IDLE). Back-to-back requests to different channels overlap freely.
- ckg_ind register:
  - next = 1 when all FSMs are IDLE and req_valid=0;
  - otherwise next = 0;
  - it updates 1 cycle after the condition.
- Time arrays hold their last issued value indefinitely. This is the reference-time semantics the consumer expects.

Optional Feature:
- Macro: PROC_CMD_ABORT_EN.
- With the macro:
  - adds input abort, NUM_CH wide, and output aborted, NUM_CH wide.
  - abort[ch]=1 while the channel is in ISSUE or WAIT forces IDLE next cycle, clears the count and busy, and pulses aborted[ch] (not done[ch]).
  - abort on an IDLE channel is ignored.
  - abort takes priority over done in the same cycle.
  - An accept to that channel is blocked in the abort cycle.
- Without the macro: the ports do not exist and waits always run to completion.

Decomposition:
- Package proc_cmd_pkg holds:
  - localparams CMD_NONE=5'd0, CMD_REL=5'd1, CMD_EXT=5'd2, CMD_EVT=5'd3;
  - req_type encodings;
  - typedef enum ch_state_e {IDLE, ISSUE, WAIT}.
- Sub-module proc_ch_timer (one per channel, generate loop):
  - contains the FSM, countdown, done and busy;
  - inputs start, type and time;
  - outputs issue strobe and type.
- Top level does:
  - accept arbitration;
  - cmd_type_M mux (OR of the per-channel issue strobes);
  - array writes;
  - ckg_ind.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_valid=1 -> req_ready=0, cmd_type_M=0, arrays=0, ckg_ind=1.
- REL to ch0, time=2, accepted at cycle T:
  - T+1: cmd_type_M=1, proc_rel_time[0]=2.
  - T+4: done[0]=1.
  - ckg_ind=0 from T+1 through the cycle after done.
- EXT ch0, time=1 at T, then EVT ch1, time=0 at T+1:
  - cmd_type_M shows 2 at T+1, then 3 at T+2.
  - done[1] at T+3, done[0] at T+3.
  - event_proc[1]=0, proc_ext_time[0]=1.
- Busy-channel block: second request to ch0 during its WAIT -> req_ready=0 until the cycle after done[0]; req_type=3 is never accepted.
- Max time: PARA=2, time=3 -> done at accept+5; count never wraps; rst asserted mid-WAIT -> no done pulse, busy=0 next cycle.
- With PROC_CMD_ABORT_EN: abort[1] in the 2nd WAIT cycle of time=3 -> aborted[1] pulses the next cycle, done[1] is never seen, and ch1 accepts again 1 cycle later.

Source files
------------

// File: rtl/proc_cmd_pkg.sv
// proc_cmd_pkg: command codes, request-type encodings and the channel
// state type shared by the proc command issuer and its channel timers.
package proc_cmd_pkg;

    localparam logic [4:0] CMD_NONE = 5'd0;
    localparam logic [4:0] CMD_REL  = 5'd1;
    localparam logic [4:0] CMD_EXT  = 5'd2;
    localparam logic [4:0] CMD_EVT  = 5'd3;

    localparam logic [1:0] REQ_REL = 2'd0;
    localparam logic [1:0] REQ_EXT = 2'd1;
    localparam logic [1:0] REQ_EVT = 2'd2;
    localparam logic [1:0] REQ_RSV = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ch_state_e;

    // Map a request type onto the command code driven on cmd_type_M.
    function automatic logic [4:0] type_to_cmd(input logic [1:0] t);
        case (t)
            REQ_REL: return CMD_REL;
            REQ_EXT: return CMD_EXT;
            REQ_EVT: return CMD_EVT;
            default: return CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/proc_cmd_issuer_if.sv
// proc_cmd_issuer_if: request handshake plus the command/time buses seen by
// the clock-gating consumer. The slave modport is the issuer; the master
// modport is the scheduler/consumer side. With PROC_CMD_ABORT_EN the
// per-channel abort/aborted signals are added.
interface proc_cmd_issuer_if #(
    parameter int PARA   = 2,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_type;
    logic [CH_W-1:0]   req_ch;
    logic [PARA-1:0]   req_time;
    logic [4:0]        cmd_type_M;
    logic [PARA-1:0]   proc_rel_time [NUM_CH];
    logic [PARA-1:0]   proc_ext_time [NUM_CH];
    logic [PARA-1:0]   event_proc    [NUM_CH];
    logic [NUM_CH-1:0] done;
    logic [NUM_CH-1:0] busy;
    logic              ckg_ind;
`ifdef PROC_CMD_ABORT_EN
    logic [NUM_CH-1:0] abort;
    logic [NUM_CH-1:0] aborted;
`endif

    modport slave (
`ifdef PROC_CMD_ABORT_EN
        input  abort,
        output aborted,
`endif
        input  req_valid, req_type, req_ch, req_time,
        output req_ready, cmd_type_M, proc_rel_time, proc_ext_time,
        output event_proc, done, busy, ckg_ind
    );

    modport master (
`ifdef PROC_CMD_ABORT_EN
        output abort,
        input  aborted,
`endif
        output req_valid, req_type, req_ch, req_time,
        input  req_ready, cmd_type_M, proc_rel_time, proc_ext_time,
        input  event_proc, done, busy, ckg_ind
    );

endinterface

// File: rtl/proc_ch_timer.sv
// proc_ch_timer: one channel's IDLE -> ISSUE -> WAIT wait tracker. The
// countdown stops at zero, so it never wraps. With PROC_CMD_ABORT_EN an
// abort input ends an active wait early, pulsing aborted instead of done.
module proc_ch_timer
    import proc_cmd_pkg::*;
#(
    parameter int PARA = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      type_i,
    input  logic [PARA-1:0] time_i,
`ifdef PROC_CMD_ABORT_EN
    input  logic            abort_i,
    output logic            aborted_o,
`endif
    output logic            issue_o,
    output logic [1:0]      type_o,
    output logic            done_o,
    output logic            busy_o,
    output logic            idle_o
);
    localparam logic [PARA-1:0] ONE = PARA'(1);

    ch_state_e       state_q, state_d;
    logic [PARA-1:0] count_q, count_d;
    logic [1:0]      type_q, type_d;
    logic            done_d;
`ifdef PROC_CMD_ABORT_EN
    logic            aborted_q, aborted_d;
`endif

    // Next state: load on start, one ISSUE cycle, count down, abort wins over done
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        type_d  = type_q;
        done_d  = 1'b0;
`ifdef PROC_CMD_ABORT_EN
        aborted_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    count_d = time_i;
                    type_d  = type_i;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    count_d = count_q - ONE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef PROC_CMD_ABORT_EN
        if (abort_i && (state_q != IDLE)) begin
            state_d   = IDLE;
            count_d   = '0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
`endif
    end

    // State registers; reset drops any wait in progress without completing it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            type_q  <= REQ_REL;
`ifdef PROC_CMD_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            type_q  <= type_d;
`ifdef PROC_CMD_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign issue_o = (state_q == ISSUE) && !rst;
    assign done_o  = done_d && !rst;
    assign type_o  = type_q;
    assign busy_o  = (state_q != IDLE);
    assign idle_o  = (state_q == IDLE);
`ifdef PROC_CMD_ABORT_EN
    assign aborted_o = aborted_q;
`endif

endmodule

// File: rtl/proc_cmd_issuer.sv
// proc_cmd_issuer: command-issuing end of the proc wait-time interface.
// Arbitrates one request per cycle onto per-channel timers, drives the
// command strobe, the per-channel time arrays and the clock-gate hint.
// Optional feature macro: PROC_CMD_ABORT_EN (per-channel abort/aborted).
module proc_cmd_issuer
    import proc_cmd_pkg::*;
#(
    parameter int PARA   = 2,
    parameter int NUM_CH = 2
) (
    input logic              clk,
    input logic              rst,
    proc_cmd_issuer_if.slave bus
);
    logic [NUM_CH-1:0] ch_idle, ch_issue, ch_done, ch_busy, ch_start;
    logic [1:0]        ch_type [NUM_CH];
    logic              accept, ch_in_range;
    logic [4:0]        cmd;
    logic [PARA-1:0]   rel_time_q [NUM_CH];
    logic [PARA-1:0]   ext_time_q [NUM_CH];
    logic [PARA-1:0]   evt_time_q [NUM_CH];
    logic              ckg_q, ckg_d;
`ifdef PROC_CMD_ABORT_EN
    logic [NUM_CH-1:0] ch_aborted;
`endif

    // Ready only for a legal type on an in-range idle channel outside reset
    always_comb begin
        ch_in_range   = (int'(bus.req_ch) < NUM_CH);
        bus.req_ready = 1'b0;
        if (!rst && ch_in_range && (bus.req_type != REQ_RSV) && ch_idle[bus.req_ch])
            bus.req_ready = 1'b1;
`ifdef PROC_CMD_ABORT_EN
        if (ch_in_range && bus.abort[bus.req_ch])
            bus.req_ready = 1'b0;
`endif
    end

    assign accept = bus.req_valid && bus.req_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_start[g] = accept && (int'(bus.req_ch) == g);

        proc_ch_timer #(.PARA(PARA)) u_timer (
            .clk      (clk),
            .rst      (rst),
            .start_i  (ch_start[g]),
            .type_i   (bus.req_type),
            .time_i   (bus.req_time),
`ifdef PROC_CMD_ABORT_EN
            .abort_i  (bus.abort[g]),
            .aborted_o(ch_aborted[g]),
`endif
            .issue_o  (ch_issue[g]),
            .type_o   (ch_type[g]),
            .done_o   (ch_done[g]),
            .busy_o   (ch_busy[g]),
            .idle_o   (ch_idle[g])
        );

        assign bus.proc_rel_time[g] = rel_time_q[g];
        assign bus.proc_ext_time[g] = ext_time_q[g];
        assign bus.event_proc[g]    = evt_time_q[g];
    end

    // At most one channel issues per cycle, so OR-ing the codes is a clean mux
    always_comb begin
        cmd = CMD_NONE;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_issue[c])
                cmd = cmd | type_to_cmd(ch_type[c]);
        end
    end

    assign bus.cmd_type_M = cmd;

    // Time arrays are written at accept so the new value is visible in ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rel_time_q[c] <= '0;
                ext_time_q[c] <= '0;
                evt_time_q[c] <= '0;
            end
        end else if (accept) begin
            case (bus.req_type)
                REQ_REL: rel_time_q[bus.req_ch] <= bus.req_time;
                REQ_EXT: ext_time_q[bus.req_ch] <= bus.req_time;
                REQ_EVT: evt_time_q[bus.req_ch] <= bus.req_time;
                default: ;
            endcase
        end
    end

    assign ckg_d = (&ch_idle) && !bus.req_valid;

    // Clock may be gated one cycle after every channel is idle with no request
    always_ff @(posedge clk) begin
        if (rst)
            ckg_q <= 1'b1;
        else
            ckg_q <= ckg_d;
    end

    assign bus.ckg_ind = ckg_q;
    assign bus.done    = ch_done;
    assign bus.busy    = ch_busy;
`ifdef PROC_CMD_ABORT_EN
    assign bus.aborted = ch_aborted;
`endif

endmodule

// File: tb/tb_proc_cmd_issuer.sv
// tb_proc_cmd_issuer: table-driven vectors, directed multi-cycle sequences
// and randomized traffic checked against a timeline model of the issuer.
module tb_proc_cmd_issuer;
    localparam int PARA   = 2;
    localparam int NUM_CH = 2;
    localparam int CH_W   = 1;

    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nErrors = 0;
    int   cyc     = 0;

    proc_cmd_issuer_if #(.PARA(PARA), .NUM_CH(NUM_CH)) bus ();

    proc_cmd_issuer #(.PARA(PARA), .NUM_CH(NUM_CH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timeline model: each channel is busy from acceptAt+1 to doneAt inclusive.
    int              acceptAt [NUM_CH];
    int              doneAt   [NUM_CH];
    logic [1:0]      typeAt   [NUM_CH];
    logic [PARA-1:0] relM     [NUM_CH];
    logic [PARA-1:0] extM     [NUM_CH];
    logic [PARA-1:0] evtM     [NUM_CH];
    bit              ckgExp;
    bit              rstPrev;
`ifdef PROC_CMD_ABORT_EN
    logic [NUM_CH-1:0] abortDrive;
    int                abortedAt [NUM_CH];
`endif

    typedef struct {
        logic              rst;
        logic              valid;
        logic [1:0]        rtype;
        logic [CH_W-1:0]   ch;
        logic [PARA-1:0]   rtime;
        logic              expReady;
        logic [4:0]        expCmd;
        logic [NUM_CH-1:0] expDone;
        logic [NUM_CH-1:0] expBusy;
        logic              expCkg;
    } vec_t;

    vec_t vecs [15];

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            acceptAt[c] = -100;
            doneAt[c]   = -100;
            typeAt[c]   = 2'd0;
            relM[c]     = '0;
            extM[c]     = '0;
            evtM[c]     = '0;
`ifdef PROC_CMD_ABORT_EN
            abortedAt[c] = -100;
`endif
        end
        ckgExp = 1'b1;
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] t,
                                 input logic [CH_W-1:0] c, input logic [PARA-1:0] tm);
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_type  = t;
        bus.req_ch    = c;
        bus.req_time  = tm;
`ifdef PROC_CMD_ABORT_EN
        bus.abort     = abortDrive;
`endif
        #1;
    endtask

    // Compare this cycle's outputs with the model, advance it, go to the next edge.
    task automatic checkOutput();
        bit [NUM_CH-1:0] busyM, doneM, abortHit;
        logic [4:0]      cmdM;
        bit              readyM, ckgNext;
        int              ch;
        ch = int'(bus.req_ch);
        if (rst) begin
            checkEq("rst_ready", 32'(bus.req_ready), 32'd0);
            checkEq("rst_cmd", 32'(bus.cmd_type_M), 32'd0);
            checkEq("rst_done", 32'(bus.done), 32'd0);
            if (rstPrev) begin
                checkEq("rst_busy", 32'(bus.busy), 32'd0);
                checkEq("rst_ckg", 32'(bus.ckg_ind), 32'd1);
                for (int c = 0; c < NUM_CH; c++) begin
                    checkEq($sformatf("rst_rel%0d", c), 32'(bus.proc_rel_time[c]), 32'd0);
                    checkEq($sformatf("rst_ext%0d", c), 32'(bus.proc_ext_time[c]), 32'd0);
                    checkEq($sformatf("rst_evt%0d", c), 32'(bus.event_proc[c]), 32'd0);
                end
            end
            modelReset();
        end else begin
            cmdM     = 5'd0;
            abortHit = '0;
            for (int c = 0; c < NUM_CH; c++)
                busyM[c] = (acceptAt[c] < cyc) && (cyc <= doneAt[c]);
`ifdef PROC_CMD_ABORT_EN
            abortHit = bus.abort & busyM;
`endif
            for (int c = 0; c < NUM_CH; c++) begin
                doneM[c] = (doneAt[c] == cyc) && !abortHit[c];
                if (acceptAt[c] == cyc - 1)
                    cmdM = cmdM | (5'(typeAt[c]) + 5'd1);
            end
            readyM = (ch < NUM_CH) && (bus.req_type != 2'd3) && !busyM[ch];
`ifdef PROC_CMD_ABORT_EN
            readyM = readyM && !bus.abort[ch];
`endif
            checkEq("ready", 32'(bus.req_ready), 32'(readyM));
            checkEq("cmd", 32'(bus.cmd_type_M), 32'(cmdM));
            checkEq("done", 32'(bus.done), 32'(doneM));
            checkEq("busy", 32'(bus.busy), 32'(busyM));
            checkEq("ckg", 32'(bus.ckg_ind), 32'(ckgExp));
            for (int c = 0; c < NUM_CH; c++) begin
                checkEq($sformatf("rel%0d", c), 32'(bus.proc_rel_time[c]), 32'(relM[c]));
                checkEq($sformatf("ext%0d", c), 32'(bus.proc_ext_time[c]), 32'(extM[c]));
                checkEq($sformatf("evt%0d", c), 32'(bus.event_proc[c]), 32'(evtM[c]));
`ifdef PROC_CMD_ABORT_EN
                checkEq($sformatf("aborted%0d", c), 32'(bus.aborted[c]), 32'(abortedAt[c] == cyc));
`endif
            end
            ckgNext = (busyM == '0) && !bus.req_valid;
`ifdef PROC_CMD_ABORT_EN
            for (int c = 0; c < NUM_CH; c++) begin
                if (abortHit[c]) begin
                    doneAt[c]    = cyc;
                    abortedAt[c] = cyc + 1;
                end
            end
`endif
            if (bus.req_valid && readyM) begin
                acceptAt[ch] = cyc;
                doneAt[ch]   = cyc + int'(bus.req_time) + 2;
                typeAt[ch]   = bus.req_type;
                case (bus.req_type)
                    2'd0:    relM[ch] = bus.req_time;
                    2'd1:    extM[ch] = bus.req_time;
                    default: evtM[ch] = bus.req_time;
                endcase
            end
            ckgExp = ckgNext;
        end
        rstPrev = rst;
        cyc++;
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   got, first, pulses;
        logic acc;

        // Hand-derived vectors: REL ch0 t=2, then EXT ch0 t=1 + EVT ch1 t=0, then a reserved type.
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 1'd0, 2'd2, 1'b1, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b0, 5'd1, 2'b00, 2'b01, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b0, 5'd0, 2'b00, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b0, 5'd0, 2'b00, 2'b01, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b0, 5'd0, 2'b01, 2'b01, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 1'd0, 2'd1, 1'b1, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'd1, 2'd0, 1'b1, 5'd2, 2'b00, 2'b01, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b0, 5'd3, 2'b00, 2'b11, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b0, 5'd0, 2'b11, 2'b11, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 1'd0, 2'd0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 2'd3, 1'd1, 2'd0, 1'b0, 5'd0, 2'b00, 2'b00, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 2'd0, 1'd1, 2'd0, 1'b1, 5'd0, 2'b00, 2'b00, 1'b0};

        modelReset();
`ifdef PROC_CMD_ABORT_EN
        abortDrive = '0;
        bus.abort  = '0;
`endif
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_type  = 2'd0;
        bus.req_ch    = 1'd0;
        bus.req_time  = 2'd1;
        @(posedge clk);
        rstPrev = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 1'd0, 2'd1);
            checkOutput();
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].rtype, vecs[i].ch, vecs[i].rtime);
            checkEq($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].expReady));
            checkEq($sformatf("vec%0d_cmd", i), 32'(bus.cmd_type_M), 32'(vecs[i].expCmd));
            checkEq($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].expDone));
            checkEq($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].expBusy));
            checkEq($sformatf("vec%0d_ckg", i), 32'(bus.ckg_ind), 32'(vecs[i].expCkg));
            checkOutput();
        end
        checkEq("tbl_rel0", 32'(bus.proc_rel_time[0]), 32'd2);
        checkEq("tbl_ext0", 32'(bus.proc_ext_time[0]), 32'd1);
        checkEq("tbl_evt1", 32'(bus.event_proc[1]), 32'd0);

        // Busy channel: ch0 with t=3 must refuse new requests until after done.
        applyStimulus(1'b0, 1'b1, 2'd0, 1'd0, 2'd3);
        acc = bus.req_ready;
        checkOutput();
        checkEq("blk_first_accept", 32'(acc), 32'd1);
        got = -1;
        for (int i = 1; i <= 12 && got < 0; i++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 1'd0, 2'd1);
            if (bus.req_ready) got = i;
            checkOutput();
        end
        checkEq("blk_reaccept_delay", 32'(got), 32'd6);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'd0, 2'd0);
            checkOutput();
        end

        // Max time on ch1: done exactly at accept+5 and only once.
        applyStimulus(1'b0, 1'b1, 2'd0, 1'd1, 2'd3);
        checkOutput();
        first  = -1;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'd1, 2'd0);
            if (bus.done[1]) begin
                pulses++;
                if (first < 0) first = i;
            end
            checkOutput();
        end
        checkEq("max_done_latency", 32'(first), 32'd5);
        checkEq("max_done_pulses", 32'(pulses), 32'd1);

        // Reset during WAIT: no completion, busy clear right after.
        applyStimulus(1'b0, 1'b1, 2'd0, 1'd0, 2'd3);
        checkOutput();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'd0, 2'd0);
            checkOutput();
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 1'd0, 2'd0);
        checkOutput();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'd0, 2'd0);
            if (i == 0) checkEq("rstmid_busy_cleared", 32'(bus.busy), 32'd0);
            if (bus.done[0]) pulses++;
            checkOutput();
        end
        checkEq("rstmid_no_done", 32'(pulses), 32'd0);

`ifdef PROC_CMD_ABORT_EN
        // Abort ch1 (t=3) in its 2nd WAIT cycle; re-accept on the next cycle.
        pulses = 0;
        applyStimulus(1'b0, 1'b1, 2'd2, 1'd1, 2'd3);
        checkOutput();
        for (int i = 1; i <= 6; i++) begin
            abortDrive = (i == 3) ? 2'b10 : 2'b00;
            if (i == 4) applyStimulus(1'b0, 1'b1, 2'd0, 1'd1, 2'd3);
            else        applyStimulus(1'b0, 1'b0, 2'd0, 1'd1, 2'd0);
            if (bus.done[1]) pulses++;
            if (i == 4) begin
                checkEq("abort_pulse", 32'(bus.aborted[1]), 32'd1);
                checkEq("abort_reaccept", 32'(bus.req_ready), 32'd1);
            end
            checkOutput();
        end
        abortDrive = '0;
        checkEq("abort_no_done", 32'(pulses), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 2'd0, 1'd0, 2'd0);
            checkOutput();
        end
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
`ifdef PROC_CMD_ABORT_EN
            abortDrive = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`endif
            applyStimulus(($urandom_range(0, 60) == 0),
                          ($urandom_range(0, 2) != 0),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, NUM_CH - 1)),
                          2'($urandom_range(0, 3)));
            checkOutput();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
